// File: rtl/vtpvic_pkg.sv
// Shared definitions for the vectored interrupt controller:
// CSR addresses, FSM state encoding and a ceiling-log2 helper.
package vtpvic_pkg;

  localparam logic [1:0] ADR_MASK = 2'd0;
  localparam logic [1:0] ADR_PEND = 2'd1;
  localparam logic [1:0] ADR_EDGE = 2'd2;
  localparam logic [1:0] ADR_STAT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Smallest r such that 2**r >= v.
  function automatic int log2c(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vtpvic_prio.sv
// Lowest-index-wins priority encoder: index of the first set request and
// a flag telling whether any request is set at all.
module vtpvic_prio #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/vtpvic.sv
// Vectored interrupt controller: N maskable level/edge request lines,
// fixed priority arbitration, vector delivery on a Wishbone interrupt
// acknowledge cycle, unaddressed-read passthrough and a small CSR port.
module vtpvic
  import vtpvic_pkg::*;
#(
  parameter int           N     = 8,
  parameter logic [N-1:0] EMODE = '0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  output logic            wb_irq_o,
  output logic [15:0]     wb_dat_o,
  input  logic            wb_stb_i,
  output logic            wb_ack_o,
  input  logic            wb_una_i,
  input  logic [15:0]     rsel,
  input  logic [N*16-1:0] ivec,
  input  logic [N-1:0]    ireq,
  output logic [N-1:0]    iack,
  input  logic            csr_stb_i,
  input  logic            csr_we_i,
  input  logic [1:0]      csr_adr_i,
  input  logic [15:0]     csr_dat_i,
  output logic [15:0]     csr_dat_o,
  output logic            csr_ack_o
);

  localparam int IW = (N > 1) ? log2c(N) : 1;

  logic [N-1:0]  mask, emode, pend, pend_nx, ireq_q, hist;
  logic [N-1:0]  eff, rise, clr, w1c;
  logic [IW-1:0] nvec, nvec_nx, win;
  logic          any, deliver, una_hit, csr_go, csr_wr;
  logic [15:0]   csr_rd;
  logic          csr_unused;
  state_t        state, state_nx;

  assign eff        = pend & mask;
  assign una_hit    = wb_stb_i & wb_una_i & ~wb_ack_o;
  assign csr_go     = csr_stb_i & ~csr_ack_o;
  assign csr_wr     = csr_go & csr_we_i;
  assign wb_irq_o   = (state == ST_REQ);
  assign csr_unused = ^csr_dat_i;

  vtpvic_prio #(.N(N), .IW(IW)) u_prio (
    .req (eff),
    .idx (win),
    .any (any)
  );

  // Pending update: level lines track ireq, edge lines latch a rising edge
  // of the registered request and clear on iack or CSR write-1 (set wins).
  always_comb begin
    w1c     = (csr_wr && csr_adr_i == ADR_PEND) ? csr_dat_i[N-1:0] : '0;
    rise    = ireq_q & ~hist;
    clr     = (iack | w1c) & emode;
    pend_nx = (emode & (rise | (pend & ~clr))) | (~emode & ireq);
  end

  // Next-state logic; nvec tracks the winner until a vector strobe freezes it.
  always_comb begin
    state_nx = state;
    nvec_nx  = nvec;
    deliver  = 1'b0;
    case (state)
      ST_IDLE: begin
        nvec_nx = win;
        if (any) state_nx = ST_REQ;
      end
      ST_REQ: begin
        if (wb_stb_i) begin
          if (!wb_una_i) begin
            state_nx = ST_ACK;
            deliver  = 1'b1;
          end
        end else begin
          nvec_nx = win;
          if (!any) state_nx = ST_IDLE;
        end
      end
      ST_ACK:  state_nx = ST_HOLD;
      ST_HOLD: if (!wb_stb_i) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, arbitration and request-history registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state  <= ST_IDLE;
      nvec   <= '0;
      pend   <= '0;
      ireq_q <= '0;
      hist   <= '0;
    end else begin
      state  <= state_nx;
      nvec   <= nvec_nx;
      pend   <= pend_nx;
      ireq_q <= ireq;
      hist   <= ireq_q;
    end
  end

  // Bus acknowledge: one-cycle vector delivery or unaddressed-read data.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      iack     <= '0;
    end else begin
      wb_ack_o <= deliver | una_hit;
      iack     <= deliver ? (N'(1) << nvec) : '0;
      if (deliver)      wb_dat_o <= ivec[int'(nvec) * 16 +: 16];
      else if (una_hit) wb_dat_o <= rsel;
    end
  end

  // CSR read multiplexer; bits at or above N read as zero.
  always_comb begin
    csr_rd = '0;
    case (csr_adr_i)
      ADR_MASK: csr_rd = 16'(mask);
      ADR_PEND: csr_rd = 16'(pend);
      ADR_EDGE: csr_rd = 16'(emode);
      ADR_STAT: csr_rd = {wb_irq_o, any, 10'b0, 4'(nvec)};
      default:  csr_rd = '0;
    endcase
  end

  // CSR registers, registered read data and single-pulse acknowledge.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      mask      <= '1;
      emode     <= EMODE;
      csr_ack_o <= 1'b0;
      csr_dat_o <= '0;
    end else begin
      csr_ack_o <= csr_go;
      if (csr_go) csr_dat_o <= csr_rd;
      if (csr_wr && csr_adr_i == ADR_MASK) mask  <= csr_dat_i[N-1:0];
      if (csr_wr && csr_adr_i == ADR_EDGE) emode <= csr_dat_i[N-1:0];
    end
  end

endmodule

// File: tb/tb_vtpvic.sv
// Directed bench for vtpvic (N=8): reset, level delivery, priority, mask,
// edge mode, unaddressed read and reset during an acknowledge.
module tb_vtpvic;

  logic          clk = 1'b0;
  logic          rst;
  logic          irq, ack, stb, una, csr_stb, csr_we, csr_ack;
  logic [15:0]   dat, rsel, csr_dat_i, csr_dat_o;
  logic [127:0]  ivec;
  logic [7:0]    ireq, iack;
  logic [1:0]    csr_adr;
  logic [15:0]   vt [8];
  int            pass_cnt = 0;
  int            total_cnt = 0;

  always #5 clk = ~clk;

  vtpvic #(.N(8), .EMODE(8'h00)) dut (
    .wb_clk_i (clk),      .wb_rst_i (rst),      .wb_irq_o (irq),
    .wb_dat_o (dat),      .wb_stb_i (stb),      .wb_ack_o (ack),
    .wb_una_i (una),      .rsel     (rsel),     .ivec     (ivec),
    .ireq     (ireq),     .iack     (iack),     .csr_stb_i(csr_stb),
    .csr_we_i (csr_we),   .csr_adr_i(csr_adr),  .csr_dat_i(csr_dat_i),
    .csr_dat_o(csr_dat_o),.csr_ack_o(csr_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [15:0] d);
    csr_stb = 1'b1; csr_we = 1'b1; csr_adr = a; csr_dat_i = d;
    tick();
    csr_stb = 1'b0; csr_we = 1'b0;
    tick();
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [15:0] d);
    csr_stb = 1'b1; csr_we = 1'b0; csr_adr = a;
    tick();
    d = csr_dat_o;
    csr_stb = 1'b0;
    tick();
  endtask

  // Runs one vector acknowledge starting in a REQ cycle; returns what was seen.
  task automatic strobe(output logic a, output logic [15:0] d, output logic [7:0] ia,
                        output logic a2);
    stb = 1'b1; una = 1'b0;
    tick();
    a = ack; d = dat; ia = iack;
    tick();
    a2 = ack | (|iack);
    stb = 1'b0;
    tick();
  endtask

  task automatic settle();
    ireq = '0; stb = 1'b0; una = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    logic [15:0] r;
    rst = 1'b1;
    #12;
    total_cnt++; if ({irq, ack, iack, csr_ack} !== 11'h0) $display("FAIL reset_ctrl: got %h want 0", {irq, ack, iack, csr_ack}); else pass_cnt++;
    total_cnt++; if ({dat, csr_dat_o} !== 32'h0) $display("FAIL reset_data: got %h want 0", {dat, csr_dat_o}); else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
    csr_read(2'd0, r);
    total_cnt++; if (r !== 16'h00FF) $display("FAIL reset_mask: got %h want 00ff", r); else pass_cnt++;
    csr_read(2'd2, r);
    total_cnt++; if (r !== 16'h0000) $display("FAIL reset_edge: got %h want 0000", r); else pass_cnt++;
    csr_read(2'd3, r);
    total_cnt++; if (r !== 16'h0000) $display("FAIL reset_stat: got %h want 0000", r); else pass_cnt++;
  endtask

  task automatic test_level();
    tick();
    ireq[5] = 1'b1;
    tick();
    total_cnt++; if (irq !== 1'b0) $display("FAIL level_irq_c1: got %b want 0", irq); else pass_cnt++;
    tick();
    total_cnt++; if (irq !== 1'b1) $display("FAIL level_irq_c2: got %b want 1", irq); else pass_cnt++;
    stb = 1'b1;
    tick();
    total_cnt++; if ({ack, dat, iack} !== {1'b1, 16'o000100, 8'h20}) $display("FAIL level_ack: got %b %o %h want 1 000100 20", ack, dat, iack); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL level_irq_ack: got %b want 0", irq); else pass_cnt++;
    tick();
    total_cnt++; if ({ack, iack, irq} !== 10'h0) $display("FAIL level_hold: got %b %h %b want 0 00 0", ack, iack, irq); else pass_cnt++;
    stb = 1'b0;
    tick();
    total_cnt++; if (irq !== 1'b0) $display("FAIL level_rearm_c1: got %b want 0", irq); else pass_cnt++;
    tick();
    total_cnt++; if (irq !== 1'b1) $display("FAIL level_rearm_c2: got %b want 1", irq); else pass_cnt++;
    ireq = '0;
    repeat (4) tick();
    total_cnt++; if (irq !== 1'b0) $display("FAIL level_withdraw: got %b want 0", irq); else pass_cnt++;
    settle();
  endtask

  task automatic test_priority();
    logic a, a2; logic [15:0] d; logic [7:0] ia;
    ireq = 8'h44;
    repeat (3) tick();
    strobe(a, d, ia, a2);
    total_cnt++; if ({a, d, ia, a2} !== {1'b1, 16'o000070, 8'h04, 1'b0}) $display("FAIL prio_first: got %b %o %h %b want 1 000070 04 0", a, d, ia, a2); else pass_cnt++;
    ireq[2] = 1'b0;
    repeat (3) tick();
    total_cnt++; if (irq !== 1'b1) $display("FAIL prio_irq2: got %b want 1", irq); else pass_cnt++;
    strobe(a, d, ia, a2);
    total_cnt++; if ({a, d, ia} !== {1'b1, 16'o000204, 8'h40}) $display("FAIL prio_second: got %b %o %h want 1 000204 40", a, d, ia); else pass_cnt++;
    settle();
  endtask

  task automatic test_mask();
    logic a, a2; logic [15:0] d, r; logic [7:0] ia;
    csr_write(2'd0, 16'h00FB);
    ireq = 8'h0C;
    repeat (3) tick();
    csr_read(2'd3, r);
    total_cnt++; if (r !== 16'hC003) $display("FAIL mask_stat: got %h want c003", r); else pass_cnt++;
    strobe(a, d, ia, a2);
    total_cnt++; if ({a, d, ia} !== {1'b1, 16'o000074, 8'h08}) $display("FAIL mask_vec: got %b %o %h want 1 000074 08", a, d, ia); else pass_cnt++;
    ireq = '0;
    csr_write(2'd0, 16'h00FF);
    settle();
  endtask

  task automatic test_edge();
    logic a, a2; logic [15:0] d, r; logic [7:0] ia;
    csr_write(2'd2, 16'h0010);
    ireq[4] = 1'b1;
    tick();
    ireq[4] = 1'b0;
    tick();
    total_cnt++; if (irq !== 1'b0) $display("FAIL edge_irq_c2: got %b want 0", irq); else pass_cnt++;
    tick();
    total_cnt++; if (irq !== 1'b1) $display("FAIL edge_irq_c3: got %b want 1", irq); else pass_cnt++;
    csr_read(2'd1, r);
    total_cnt++; if (r !== 16'h0010) $display("FAIL edge_pend_set: got %h want 0010", r); else pass_cnt++;
    strobe(a, d, ia, a2);
    total_cnt++; if ({a, d, ia} !== {1'b1, 16'o000200, 8'h10}) $display("FAIL edge_vec: got %b %o %h want 1 000200 10", a, d, ia); else pass_cnt++;
    csr_read(2'd1, r);
    total_cnt++; if (r !== 16'h0000) $display("FAIL edge_pend_clr: got %h want 0000", r); else pass_cnt++;
    ireq[4] = 1'b1;
    tick();
    ireq[4] = 1'b0;
    repeat (2) tick();
    stb = 1'b1;
    tick();
    total_cnt++; if ({ack, iack} !== {1'b1, 8'h10}) $display("FAIL edge_ack2: got %b %h want 1 10", ack, iack); else pass_cnt++;
    ireq[4] = 1'b1;
    tick();
    ireq[4] = 1'b0; stb = 1'b0;
    repeat (2) tick();
    csr_read(2'd1, r);
    total_cnt++; if (r !== 16'h0010) $display("FAIL edge_pend_during_ack: got %h want 0010", r); else pass_cnt++;
    csr_write(2'd1, 16'h0010);
    csr_read(2'd1, r);
    total_cnt++; if (r !== 16'h0000) $display("FAIL edge_w1c: got %h want 0000", r); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL edge_irq_after_w1c: got %b want 0", irq); else pass_cnt++;
    csr_write(2'd2, 16'h0000);
    settle();
  endtask

  task automatic test_una();
    logic a, a2; logic [15:0] d; logic [7:0] ia;
    ireq[1] = 1'b1;
    repeat (3) tick();
    stb = 1'b1; una = 1'b1; rsel = 16'o177777;
    tick();
    total_cnt++; if ({ack, dat, iack} !== {1'b1, 16'o177777, 8'h00}) $display("FAIL una_ack: got %b %o %h want 1 177777 00", ack, dat, iack); else pass_cnt++;
    total_cnt++; if (irq !== 1'b1) $display("FAIL una_state: got %b want 1", irq); else pass_cnt++;
    stb = 1'b0; una = 1'b0;
    tick();
    total_cnt++; if (ack !== 1'b0) $display("FAIL una_pulse: got %b want 0", ack); else pass_cnt++;
    strobe(a, d, ia, a2);
    total_cnt++; if ({a, d, ia} !== {1'b1, 16'o000064, 8'h02}) $display("FAIL una_then_vec: got %b %o %h want 1 000064 02", a, d, ia); else pass_cnt++;
    settle();
  endtask

  task automatic test_reset_mid();
    logic [15:0] r;
    logic        seen;
    ireq[7] = 1'b1;
    repeat (3) tick();
    stb = 1'b1;
    tick();
    total_cnt++; if (ack !== 1'b1) $display("FAIL rstmid_in_ack: got %b want 1", ack); else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    total_cnt++; if ({irq, ack, dat, iack} !== 26'h0) $display("FAIL rstmid_outputs: got %b %b %h %h want 0", irq, ack, dat, iack); else pass_cnt++;
    ireq = '0; stb = 1'b0;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | (|iack) | ack;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL rstmid_no_iack: got %b want 0", seen); else pass_cnt++;
    csr_read(2'd1, r);
    total_cnt++; if (r !== 16'h0000) $display("FAIL rstmid_pend: got %h want 0000", r); else pass_cnt++;
  endtask

  initial begin
    vt[0] = 16'o000060; vt[1] = 16'o000064; vt[2] = 16'o000070; vt[3] = 16'o000074;
    vt[4] = 16'o000200; vt[5] = 16'o000100; vt[6] = 16'o000204; vt[7] = 16'o000210;
    for (int i = 0; i < 8; i++) ivec[16*i +: 16] = vt[i];
    rst = 1'b1; stb = 1'b0; una = 1'b0; rsel = '0; ireq = '0;
    csr_stb = 1'b0; csr_we = 1'b0; csr_adr = '0; csr_dat_i = '0;
    test_reset();
    test_level();
    test_priority();
    test_mask();
    test_edge();
    test_una();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/vtpvic.md
# vtpvic

Parametrised vectored interrupt controller, next generation of the VT52 system's single-level vector controller. It accepts N request lines, each configurable at runtime as level- or edge-sensitive and individually maskable. It arbitrates by fixed priority and supplies the winning 16-bit vector to the CPU over a Wishbone interrupt-acknowledge cycle, with unaddressed-read passthrough. A small CSR port exposes the mask, pending and mode registers.

## Interface
- N, 8, number of interrupt lines, 1..16; line 0 has highest priority
- EMODE, {N{1'b0}}, reset value of the edge-mode register (1 = edge-sensitive)
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- wb_irq_o  out  1  vectored interrupt request to the CPU
- wb_dat_o  out  16  vector or unaddressed-read data
- wb_stb_i  in  1  interrupt-acknowledge / unaddressed-read strobe
- wb_ack_o  out  1  strobe acknowledge, one-cycle pulse
- wb_una_i  in  1  unaddressed-read tag
- rsel  in  16  unaddressed-read content
- ivec  in  N*16  vectors; line i uses ivec[16i+15:16i]
- ireq  in  N  request lines
- iack  out  N  per-line acknowledge, one-cycle pulse
- csr_stb_i  in  1  CSR strobe
- csr_we_i  in  1  CSR write enable
- csr_adr_i  in  2  CSR register select
- csr_dat_i  in  16  CSR write data
- csr_dat_o  out  16  CSR read data
- csr_ack_o  out  1  CSR acknowledge

## Operation
- **Pending register pend[N]:**
  - Level line: pend[i] follows ireq[i] each cycle.
  - Edge line: pend[i] is set on a registered 0→1 transition of ireq[i].
  - Edge pend[i] is cleared by iack[i] or by a CSR write-1 to PEND. Set wins over clear in the same cycle.
- **Effective requests:** eff = pend & mask. The winner is the lowest index set in eff.
- **FSM states:** IDLE, REQ, ACK, HOLD.
  - IDLE: winner latched into nvec every cycle. Go to REQ when eff≠0.
  - REQ: wb_irq_o=1. While wb_stb_i=0, nvec re-arbitrates each cycle, and the FSM returns to IDLE if eff becomes 0. When wb_stb_i=1 and wb_una_i=0, nvec freezes and the FSM goes to ACK.
  - ACK (one cycle): wb_ack_o=1, wb_dat_o=ivec slice at nvec, iack[nvec]=1, wb_irq_o=0. Go to HOLD.
  - HOLD: wb_irq_o=0. Go to IDLE when wb_stb_i=0.
- **Delivery after request loss:** if the winning level request drops after nvec freezes, the frozen vector and iack are still delivered. No spurious-vector substitution.
- **Unaddressed read:** wb_stb_i & wb_una_i & ~wb_ack_o in any state gives wb_ack_o=1 next cycle with wb_dat_o=rsel. No iack is pulsed, and FSM state and pend are unchanged.
- **CSR map** (csr_ack_o one cycle after csr_stb_i & ~csr_ack_o; csr_dat_o registered, bits ≥N read 0):
  - 0 MASK: read/write. Reset 16'hFFFF truncated to N bits.
  - 1 PEND: read pend; write-1-clears edge pend bits. Level bits are unaffected.
  - 2 EDGE: read/write mode register. Reset EMODE.
  - 3 STAT: read-only. bit15 = wb_irq_o, bit14 = eff≠0, bits 3:0 = nvec.
- Mask and mode changes take effect on the arbitration cycle after the write.

## Timing
- **Reset values:** wb_irq_o=0, wb_ack_o=0, wb_dat_o=0, iack=0, csr_ack_o=0, csr_dat_o=0, pend=0, edge history=0, FSM=IDLE, nvec=0.
- **Request to IRQ:**
  - Level ireq rises at cycle 0: pend at 1, REQ entered at 2, wb_irq_o high at 2.
  - Edge lines add one cycle for edge detection.
- **Strobe to acknowledge:** wb_stb_i seen in REQ at cycle k gives wb_ack_o, wb_dat_o and iack all valid at k+1, for exactly one cycle.
- Acknowledge never repeats while wb_stb_i is held.
- The next IRQ can assert no earlier than two cycles after wb_stb_i falls.
- **Reset mid-cycle:** asynchronous reset clears everything immediately. An in-flight acknowledge is dropped with no iack.

## Structure
- Shared package holds the CSR address constants (ADR_MASK=0, ADR_PEND=1, ADR_EDGE=2, ADR_STAT=3), the FSM state encoding, and the log2 helper.
- One natural sub-module: vtpvic_prio, a combinational N-input lowest-index priority encoder giving index and any-valid.

## Test plan
- **Level delivery:** N=8, ireq[5]=1, ivec slice 5=16'o000100, then strobe → wb_irq_o at +2, then wb_ack_o, wb_dat_o=16'o000100 and iack[5] for one cycle.
- **Priority:** ireq[2] and ireq[6] both high → vector 2 delivered. Then drop ireq[2] and strobe again → vector 6 delivered.
- **Mask:** write MASK=8'hFB, ireq[2] and ireq[3] high → vector 3 delivered. STAT reads bit15=1 and nvec=3 before the strobe.
- **Edge mode:** EDGE=bit4 set, ireq[4] pulses for one cycle → PEND bit4=1 and wb_irq_o asserts. After the acknowledge PEND=0. A second pulse arriving during ACK leaves PEND bit4=1.
- **Unaddressed read:** wb_una_i=1, rsel=16'o177777 while ireq[1] is pending → wb_ack_o with wb_dat_o=16'o177777, iack=0. A subsequent normal strobe still yields vector 1.
- **Reset mid-operation:** assert wb_rst_i in the ACK cycle → all outputs 0 immediately, pend=0, and no iack pulse after reset release.
